// File: rtl/rv_execute_if.sv
// Decode/control <-> execute stage bundle: Q102H operands and control in, branch redirect,
// MDU stall and Q103H pipeline registers out.
interface rv_execute_if;
  logic        valid_Q102H;
  logic        flush_Q102H;
  logic        ready_Q103H;
  logic [31:0] pc_Q102H;
  logic [31:0] imm_Q102H;
  logic [31:0] reg_data1_Q102H;
  logic [31:0] reg_data2_Q102H;
  logic [4:0]  alu_op_Q102H;
  logic        sel_src1_pc_Q102H;
  logic        sel_src2_imm_Q102H;
  logic [2:0]  br_type_Q102H;

  logic        stall_Q102H;
  logic        br_taken_Q102H;
  logic [31:0] br_target_Q102H;
  logic [31:0] alu_out_Q103H;
  logic [31:0] store_data_Q103H;
  logic [31:0] pc_Q103H;
  logic        valid_Q103H;

  modport master (
    output valid_Q102H, flush_Q102H, ready_Q103H, pc_Q102H, imm_Q102H,
           reg_data1_Q102H, reg_data2_Q102H, alu_op_Q102H, sel_src1_pc_Q102H,
           sel_src2_imm_Q102H, br_type_Q102H,
    input  stall_Q102H, br_taken_Q102H, br_target_Q102H, alu_out_Q103H,
           store_data_Q103H, pc_Q103H, valid_Q103H
  );

  modport slave (
    input  valid_Q102H, flush_Q102H, ready_Q103H, pc_Q102H, imm_Q102H,
           reg_data1_Q102H, reg_data2_Q102H, alu_op_Q102H, sel_src1_pc_Q102H,
           sel_src2_imm_Q102H, br_type_Q102H,
    output stall_Q102H, br_taken_Q102H, br_target_Q102H, alu_out_Q103H,
           store_data_Q103H, pc_Q103H, valid_Q103H
  );
endinterface

// File: rtl/rv_execute.sv
// RV32IM execute stage: single-cycle ALU, branch resolution and an iterative radix-2
// multiply/divide unit that stalls Q102H while it runs; results register into Q103H.
module rv_execute #(
  parameter int unsigned MDU_ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  rv_execute_if.slave ex
);

  localparam int unsigned CntW = $clog2(MDU_ITER) + 1;

  localparam logic [4:0] OpAdd    = 5'd0;
  localparam logic [4:0] OpSub    = 5'd1;
  localparam logic [4:0] OpSll    = 5'd2;
  localparam logic [4:0] OpSlt    = 5'd3;
  localparam logic [4:0] OpSltu   = 5'd4;
  localparam logic [4:0] OpXor    = 5'd5;
  localparam logic [4:0] OpSrl    = 5'd6;
  localparam logic [4:0] OpSra    = 5'd7;
  localparam logic [4:0] OpOr     = 5'd8;
  localparam logic [4:0] OpAnd    = 5'd9;
  localparam logic [4:0] OpPassB  = 5'd10;
  localparam logic [4:0] OpMul    = 5'd11;
  localparam logic [4:0] OpMulh   = 5'd12;
  localparam logic [4:0] OpMulhsu = 5'd13;
  localparam logic [4:0] OpMulhu  = 5'd14;
  localparam logic [4:0] OpDiv    = 5'd15;
  localparam logic [4:0] OpDivu   = 5'd16;
  localparam logic [4:0] OpRem    = 5'd17;
  localparam logic [4:0] OpRemu   = 5'd18;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} mdu_state_e;

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     p_q, p_d;      // {remainder, quotient} or {product hi, multiplier}
  logic [31:0]     d_q, d_d;      // multiplicand or divisor magnitude
  logic [4:0]      op_q, op_d;
  logic            sa_q, sa_d, sb_q, sb_d, div0_q, div0_d;

  logic [31:0] alu_out_q, store_data_q, pc_out_q;
  logic        valid_out_q;

  logic [31:0] op_a, op_b, alu_res, mdu_res, res_sel;
  logic [4:0]  shamt;
  logic        cond, jump, is_mdu, mdu_req, stall, load;
  logic        a_signed, b_signed, sa, sb;
  logic [31:0] abs_a, abs_b;

  assign op_a  = ex.sel_src1_pc_Q102H  ? ex.pc_Q102H  : ex.reg_data1_Q102H;
  assign op_b  = ex.sel_src2_imm_Q102H ? ex.imm_Q102H : ex.reg_data2_Q102H;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = 32'd0;
    case (ex.alu_op_Q102H)
      OpAdd:   alu_res = op_a + op_b;
      OpSub:   alu_res = op_a - op_b;
      OpSll:   alu_res = op_a << shamt;
      OpSlt:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      OpSltu:  alu_res = {31'd0, op_a < op_b};
      OpXor:   alu_res = op_a ^ op_b;
      OpSrl:   alu_res = op_a >> shamt;
      OpSra:   alu_res = $signed(op_a) >>> shamt;
      OpOr:    alu_res = op_a | op_b;
      OpAnd:   alu_res = op_a & op_b;
      OpPassB: alu_res = op_b;
      default: alu_res = 32'd0;
    endcase
  end

  // Branch compare always uses the register operands, independent of the ALU muxes.
  always_comb begin
    cond = 1'b0;
    case (ex.br_type_Q102H)
      3'd1:    cond = ex.reg_data1_Q102H == ex.reg_data2_Q102H;
      3'd2:    cond = ex.reg_data1_Q102H != ex.reg_data2_Q102H;
      3'd3:    cond = $signed(ex.reg_data1_Q102H) <  $signed(ex.reg_data2_Q102H);
      3'd4:    cond = $signed(ex.reg_data1_Q102H) >= $signed(ex.reg_data2_Q102H);
      3'd5:    cond = ex.reg_data1_Q102H <  ex.reg_data2_Q102H;
      3'd6:    cond = ex.reg_data1_Q102H >= ex.reg_data2_Q102H;
      3'd7:    cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign jump = ex.br_type_Q102H == 3'd7;
  assign ex.br_taken_Q102H  = ex.valid_Q102H & ~ex.flush_Q102H & cond;
  assign ex.br_target_Q102H = (jump & ~ex.sel_src1_pc_Q102H) ?
                              ((ex.reg_data1_Q102H + ex.imm_Q102H) & ~32'd1) :
                              (ex.pc_Q102H + ex.imm_Q102H);

  assign is_mdu  = (ex.alu_op_Q102H >= OpMul) && (ex.alu_op_Q102H <= OpRemu);
  assign mdu_req = ex.valid_Q102H & ~ex.flush_Q102H & is_mdu;

  // Signed-magnitude operands; MUL low word is sign-agnostic so it runs unsigned.
  assign a_signed = (ex.alu_op_Q102H == OpMulh) || (ex.alu_op_Q102H == OpMulhsu) ||
                    (ex.alu_op_Q102H == OpDiv)  || (ex.alu_op_Q102H == OpRem);
  assign b_signed = (ex.alu_op_Q102H == OpMulh) || (ex.alu_op_Q102H == OpDiv) ||
                    (ex.alu_op_Q102H == OpRem);
  assign sa    = a_signed & op_a[31];
  assign sb    = b_signed & op_b[31];
  assign abs_a = sa ? (32'd0 - op_a) : op_a;
  assign abs_b = sb ? (32'd0 - op_b) : op_b;

  logic [32:0] sum33, r33, diff33;
  logic [63:0] mul_step, div_step;
  logic        op_div_q;

  assign op_div_q = op_q >= OpDiv;
  assign sum33    = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, d_q} : 33'd0);
  assign mul_step = {sum33, p_q[31:1]};
  assign r33      = {p_q[63:32], p_q[31]};
  assign diff33   = r33 - {1'b0, d_q};
  assign div_step = diff33[32] ? {r33[31:0], p_q[30:0], 1'b0} :
                                 {diff33[31:0], p_q[30:0], 1'b1};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    d_d     = d_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div0_d  = div0_q;
    stall   = 1'b0;
    case (state_q)
      StIdle: begin
        if (mdu_req) begin
          stall   = 1'b1;
          p_d     = {32'd0, abs_a};
          d_d     = abs_b;
          op_d    = ex.alu_op_Q102H;
          sa_d    = sa;
          sb_d    = sb;
          div0_d  = op_b == 32'd0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        stall = 1'b1;
        p_d   = op_div_q ? div_step : mul_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(MDU_ITER - 1)) state_d = StDone;
      end
      StDone: begin
        if (ex.ready_Q103H) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (ex.flush_Q102H) state_d = StIdle;
  end

  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign prod = (sa_q ^ sb_q) ? (64'd0 - p_q) : p_q;
  assign quo  = div0_q ? 32'hFFFF_FFFF : ((sa_q ^ sb_q) ? (32'd0 - p_q[31:0]) : p_q[31:0]);
  assign rem  = sa_q ? (32'd0 - p_q[63:32]) : p_q[63:32];

  always_comb begin
    mdu_res = 32'd0;
    case (op_q)
      OpMul:                       mdu_res = prod[31:0];
      OpMulh, OpMulhsu, OpMulhu:   mdu_res = prod[63:32];
      OpDiv, OpDivu:               mdu_res = quo;
      OpRem, OpRemu:               mdu_res = rem;
      default:                     mdu_res = 32'd0;
    endcase
  end

  assign res_sel = (state_q == StDone) ? mdu_res :
                   jump                ? (ex.pc_Q102H + 32'd4) : alu_res;
  assign load    = ex.ready_Q103H & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      p_q     <= 64'd0;
      d_q     <= 32'd0;
      op_q    <= 5'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      d_q     <= d_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div0_q  <= div0_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q    <= 32'd0;
      store_data_q <= 32'd0;
      pc_out_q     <= 32'd0;
      valid_out_q  <= 1'b0;
    end else if (load) begin
      alu_out_q    <= res_sel;
      store_data_q <= ex.reg_data2_Q102H;
      pc_out_q     <= ex.pc_Q102H;
      valid_out_q  <= ex.valid_Q102H & ~ex.flush_Q102H;
    end
  end

  assign ex.stall_Q102H      = stall;
  assign ex.alu_out_Q103H    = alu_out_q;
  assign ex.store_data_Q103H = store_data_q;
  assign ex.pc_Q103H         = pc_out_q;
  assign ex.valid_Q103H      = valid_out_q;

endmodule

// File: tb/tb_rv_execute.sv
// Vector table plus hand-written ready-hold, flush and async-reset sequences for rv_execute.
module tb_rv_execute;

  logic clk;
  logic rst_n;

  rv_execute_if ex_if ();

  rv_execute #(.MDU_ITER(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ex    (ex_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  br;
    logic        s1pc;
    logic        s2imm;
    logic        flush;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] res;
    logic        taken;
    logic [31:0] target;
    int          stalls;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [31:0] pc;
    logic [31:0] sd;
    logic        valid;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  vec_t mul_v;
  int   n_vec;
  int   n_err;

  function automatic vec_t mk(input logic [4:0] op, input logic [2:0] br, input logic s1pc,
                              input logic s2imm, input logic flush, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] res,
                              input logic taken, input logic [31:0] target, input int stalls);
    vec_t v;
    v.op = op; v.br = br; v.s1pc = s1pc; v.s2imm = s2imm; v.flush = flush;
    v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.res = res;
    v.taken = taken; v.target = target; v.stalls = stalls;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic rdy);
    ex_if.valid_Q102H        = 1'b1;
    ex_if.flush_Q102H        = v.flush;
    ex_if.ready_Q103H        = rdy;
    ex_if.pc_Q102H           = v.pc;
    ex_if.imm_Q102H          = v.imm;
    ex_if.reg_data1_Q102H    = v.rs1;
    ex_if.reg_data2_Q102H    = v.rs2;
    ex_if.alu_op_Q102H       = v.op;
    ex_if.sel_src1_pc_Q102H  = v.s1pc;
    ex_if.sel_src2_imm_Q102H = v.s2imm;
    ex_if.br_type_Q102H      = v.br;
  endtask

  task automatic wait_stall(output int n);
    n = 0;
    while (ex_if.stall_Q102H === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic issue(input vec_t v, input int idx);
    exp_t e;
    int   n;
    @(negedge clk);
    drive(v, 1'b1);
    sb.push_back('{res: v.res, pc: v.pc, sd: v.rs2, valid: ~v.flush});
    #1;
    chk($sformatf("v%0d br_taken", idx), {31'd0, ex_if.br_taken_Q102H}, {31'd0, v.taken});
    if (v.taken) chk($sformatf("v%0d br_target", idx), ex_if.br_target_Q102H, v.target);
    wait_stall(n);
    chk($sformatf("v%0d stall_cycles", idx), 32'(n), 32'(v.stalls));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d valid_Q103H", idx), {31'd0, ex_if.valid_Q103H}, {31'd0, e.valid});
    if (e.valid) begin
      chk($sformatf("v%0d alu_out", idx), ex_if.alu_out_Q103H, e.res);
      chk($sformatf("v%0d pc_Q103H", idx), ex_if.pc_Q103H, e.pc);
      chk($sformatf("v%0d store_data", idx), ex_if.store_data_Q103H, e.sd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;

    // op br s1pc s2imm flush pc imm rs1 rs2 res taken target stalls
    vq.push_back(mk(0, 0, 0, 1, 0, 'h10, 'hFFFF_FFFD, 7, 0, 4, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 'h14, 0, 5, 8, 'hFFFF_FFFD, 0, 0, 0));
    vq.push_back(mk(2, 0, 0, 0, 0, 'h18, 0, 1, 'h24, 'h10, 0, 0, 0));
    vq.push_back(mk(3, 0, 0, 0, 0, 'h1C, 0, 'hFFFF_FFFF, 1, 1, 0, 0, 0));
    vq.push_back(mk(4, 0, 0, 0, 0, 'h20, 0, 'hFFFF_FFFF, 1, 0, 0, 0, 0));
    vq.push_back(mk(5, 0, 0, 0, 0, 'h24, 0, 'hF0F0_F0F0, 'hFF00_FF00, 'h0FF0_0FF0, 0, 0, 0));
    vq.push_back(mk(6, 0, 0, 0, 0, 'h28, 0, 'h8000_0000, 4, 'h0800_0000, 0, 0, 0));
    vq.push_back(mk(7, 0, 0, 0, 0, 'h2C, 0, 'h8000_0000, 4, 'hF800_0000, 0, 0, 0));
    vq.push_back(mk(8, 0, 0, 0, 0, 'h30, 0, 'h0F00, 'h00F0, 'h0FF0, 0, 0, 0));
    vq.push_back(mk(9, 0, 0, 0, 0, 'h34, 0, 'hFF00, 'h0FF0, 'h0F00, 0, 0, 0));
    vq.push_back(mk(10, 0, 0, 1, 0, 'h38, 'h1234_5000, 1, 2, 'h1234_5000, 0, 0, 0));
    vq.push_back(mk(25, 0, 0, 0, 0, 'h3C, 0, 3, 4, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 'h1000, 'h20, 9, 9, 'h1020, 0, 0, 0));
    vq.push_back(mk(0, 3, 0, 0, 0, 'h100, 'h20, 'hFFFF_FFFF, 1, 0, 1, 'h120, 0));
    vq.push_back(mk(0, 5, 0, 0, 0, 'h100, 'h20, 'hFFFF_FFFF, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 'h200, 'hFFFF_FFF8, 5, 5, 10, 1, 'h1F8, 0));
    vq.push_back(mk(0, 2, 0, 0, 0, 'h200, 'hFFFF_FFF8, 5, 5, 10, 0, 0, 0));
    vq.push_back(mk(0, 4, 0, 0, 0, 'h300, 'h40, 'hFFFF_FFFF, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 6, 0, 0, 0, 'h300, 'h40, 'hFFFF_FFFF, 1, 0, 1, 'h340, 0));
    vq.push_back(mk(0, 7, 0, 1, 0, 'h40, 4, 'h1003, 0, 'h44, 1, 'h1006, 0));
    vq.push_back(mk(0, 7, 1, 1, 0, 'h80, 'h100, 0, 0, 'h84, 1, 'h180, 0));
    vq.push_back(mk(0, 7, 1, 1, 1, 'h90, 'h100, 0, 0, 0, 0, 0, 0));
    mul_v = mk(11, 0, 0, 0, 0, 'h400, 0, 'hFFFF_FFFF, 3, 'hFFFF_FFFD, 0, 0, 33);
    vq.push_back(mul_v);
    vq.push_back(mk(14, 0, 0, 0, 0, 'h404, 0, 'hFFFF_FFFF, 3, 2, 0, 0, 33));
    vq.push_back(mk(12, 0, 0, 0, 0, 'h408, 0, 'hFFFF_FFFF, 3, 'hFFFF_FFFF, 0, 0, 33));
    vq.push_back(mk(13, 0, 0, 0, 0, 'h40C, 0, 'hFFFF_FFFF, 'hFFFF_FFFF, 'hFFFF_FFFF, 0, 0, 33));
    vq.push_back(mk(14, 0, 0, 0, 0, 'h410, 0, 'h8000_0000, 'h8000_0000, 'h4000_0000, 0, 0, 33));
    vq.push_back(mk(12, 0, 0, 0, 0, 'h414, 0, 'h8000_0000, 'h8000_0000, 'h4000_0000, 0, 0, 33));
    vq.push_back(mk(11, 0, 0, 0, 0, 'h418, 0, 'h1234_5678, 'h10, 'h2345_6780, 0, 0, 33));
    vq.push_back(mk(15, 0, 0, 0, 0, 'h41C, 0, 'hFFFF_FFF9, 2, 'hFFFF_FFFD, 0, 0, 33));
    vq.push_back(mk(17, 0, 0, 0, 0, 'h420, 0, 'hFFFF_FFF9, 2, 'hFFFF_FFFF, 0, 0, 33));
    vq.push_back(mk(15, 0, 0, 0, 0, 'h424, 0, 'h1234, 0, 'hFFFF_FFFF, 0, 0, 33));
    vq.push_back(mk(17, 0, 0, 0, 0, 'h428, 0, 'hFFFF_FFF9, 0, 'hFFFF_FFF9, 0, 0, 33));
    vq.push_back(mk(16, 0, 0, 0, 0, 'h42C, 0, 'hFFFF_FFFF, 0, 'hFFFF_FFFF, 0, 0, 33));
    vq.push_back(mk(16, 0, 0, 0, 0, 'h430, 0, 100, 7, 14, 0, 0, 33));
    vq.push_back(mk(18, 0, 0, 0, 0, 'h434, 0, 100, 7, 2, 0, 0, 33));
    vq.push_back(mk(17, 0, 0, 0, 0, 'h438, 0, 'h8000_0000, 'hFFFF_FFFF, 0, 0, 0, 33));
    vq.push_back(mk(15, 0, 0, 0, 0, 'h43C, 0, 'h8000_0000, 'hFFFF_FFFF, 'h8000_0000, 0, 0, 33));

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1);
    ex_if.valid_Q102H = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset alu_out", ex_if.alu_out_Q103H, 0);
    chk("reset valid", {31'd0, ex_if.valid_Q103H}, 0);
    chk("reset pc", ex_if.pc_Q103H, 0);
    chk("reset store_data", ex_if.store_data_Q103H, 0);
    chk("reset stall", {31'd0, ex_if.stall_Q102H}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) issue(vq[i], i);

    // MDU result must survive ready_Q103H=0 while DONE is held.
    issue(vq[0], 100);
    @(negedge clk);
    drive(mk(16, 0, 0, 0, 0, 'h500, 0, 100, 7, 0, 0, 0, 0), 1'b0);
    #1;
    wait_stall(n);
    chk("hold stall_cycles", 32'(n), 33);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d alu_out", k), ex_if.alu_out_Q103H, 4);
      chk($sformatf("hold%0d stall", k), {31'd0, ex_if.stall_Q102H}, 0);
    end
    @(negedge clk);
    ex_if.ready_Q103H = 1'b1;
    @(posedge clk);
    #1;
    chk("hold release alu_out", ex_if.alu_out_Q103H, 14);
    chk("hold release pc", ex_if.pc_Q103H, 'h500);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 'h504, 0, 1, 2, 0, 0, 0, 0), 1'b0);
    @(posedge clk);
    #1;
    chk("ready0 alu_out held", ex_if.alu_out_Q103H, 14);
    chk("ready0 pc held", ex_if.pc_Q103H, 'h500);
    chk("ready0 valid held", {31'd0, ex_if.valid_Q103H}, 1);

    // Flush at CALC step 10.
    @(negedge clk);
    drive(mul_v, 1'b1);
    repeat (11) @(negedge clk);
    ex_if.flush_Q102H = 1'b1;
    #1;
    chk("flush stall same cycle", {31'd0, ex_if.stall_Q102H}, 1);
    @(negedge clk);
    ex_if.flush_Q102H = 1'b0;
    ex_if.valid_Q102H = 1'b0;
    #1;
    chk("flush stall next cycle", {31'd0, ex_if.stall_Q102H}, 0);
    @(posedge clk);
    #1;
    chk("flush valid_Q103H", {31'd0, ex_if.valid_Q103H}, 0);
    issue(mul_v, 200);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    drive(mul_v, 1'b1);
    repeat (5) @(negedge clk);
    #3;
    rst_n = 1'b0;
    ex_if.valid_Q102H = 1'b0;
    #1;
    chk("midrst alu_out", ex_if.alu_out_Q103H, 0);
    chk("midrst valid", {31'd0, ex_if.valid_Q103H}, 0);
    chk("midrst pc", ex_if.pc_Q103H, 0);
    chk("midrst store_data", ex_if.store_data_Q103H, 0);
    chk("midrst stall", {31'd0, ex_if.stall_Q102H}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(mul_v, 300);

    @(negedge clk);
    ex_if.valid_Q102H = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
